// File: rtl/event_counter_bank_if.sv
// Event strobe / clear inputs and registered count, overflow and tick outputs
// of event_counter_bank, bundled so the bank and its driver share one port.
interface event_counter_bank_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 64,
    parameter int SEL_W = 2
) ();
    logic                   En;
    logic [SEL_W-1:0]       Sel;
    logic [NCH-1:0]         Clr;
    logic [NCH*WIDTH-1:0]   Count;
    logic [NCH-1:0]         Ovf;
    logic [NCH-1:0]         Tick;

    modport master (output En, Sel, Clr, input Count, Ovf, Tick);
    modport slave  (input En, Sel, Clr, output Count, Ovf, Tick);
endinterface

// File: rtl/event_counter_bank.sv
// Bank of NCH prescaled event counters with sticky overflow and tick pulses.
// Define ECB_SATURATE_EN to saturate at all-ones instead of wrapping.
module ecb_lane #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ev,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             tick
);
    localparam int PW = $clog2(DIV + 1);

    logic [PW-1:0] pre;

    // With DIV=1 the prescaler never leaves 0, so every event hits the terminal value.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            pre   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (ev) begin
                if (pre == PW'(DIV - 1)) begin
                    pre <= '0;
`ifdef ECB_SATURATE_EN
                    if (&count) begin
                        ovf <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                        tick  <= 1'b1;
                    end
`else
                    if (&count) ovf <= 1'b1;
                    count <= count + WIDTH'(1);
                    tick  <= 1'b1;
`endif
                end else begin
                    pre <= pre + PW'(1);
                end
            end
        end
    end
endmodule

module event_counter_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 64,
    parameter int DIV   = 4,
    parameter int SEL_W = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    event_counter_bank_if.slave bus
);
    logic [NCH-1:0][WIDTH-1:0] cnt;
    logic [NCH-1:0]            ovf;
    logic [NCH-1:0]            tick;

    // Sel values at or above NCH match no lane and are dropped.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        ecb_lane #(.WIDTH(WIDTH), .DIV(DIV)) u_lane (
            .Clk   (Clk),
            .Reset (Reset),
            .ev    (bus.En && (bus.Sel == SEL_W'(k))),
            .clr   (bus.Clr[k]),
            .count (cnt[k]),
            .ovf   (ovf[k]),
            .tick  (tick[k])
        );
    end

    assign bus.Count = cnt;
    assign bus.Ovf   = ovf;
    assign bus.Tick  = tick;
endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench: default bank (DIV=4) plus a narrow DIV=1, WIDTH=4, NCH=3 bank.
module tb_event_counter_bank;
    logic Clk = 1'b0;
    logic Reset;
    int   nchk = 0;
    int   npass = 0;
    int   ta [4];
    int   tb [3];

    always #5 Clk = ~Clk;

    event_counter_bank_if #(.NCH(4), .WIDTH(64), .SEL_W(2)) ia ();
    event_counter_bank_if #(.NCH(3), .WIDTH(4),  .SEL_W(2)) ib ();

    event_counter_bank #(.NCH(4), .WIDTH(64), .DIV(4), .SEL_W(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(ia.slave));
    event_counter_bank #(.NCH(3), .WIDTH(4), .DIV(1), .SEL_W(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(ib.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and ticks tallied.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            for (int k = 0; k < 4; k++) ta[k] += int'(ia.Tick[k]);
            for (int k = 0; k < 3; k++) tb[k] += int'(ib.Tick[k]);
        end
    endtask

    function automatic logic [63:0] ca(input int k);
        return ia.Count[k*64 +: 64];
    endfunction

    function automatic logic [63:0] cb(input int k);
        return 64'(ib.Count[k*4 +: 4]);
    endfunction

    task automatic clr_ticks();
        for (int k = 0; k < 4; k++) ta[k] = 0;
        for (int k = 0; k < 3; k++) tb[k] = 0;
    endtask

    initial begin
        Reset = 1'b1;
        ia.En = 1'b0; ia.Sel = '0; ia.Clr = '0;
        ib.En = 1'b0; ib.Sel = '0; ib.Clr = '0;
        @(negedge Clk);
        cyc();
        Reset = 1'b0;
        chk("rst_count_a", 64'(ia.Count != 0), 64'd0);
        chk("rst_ovf_a",   64'(ia.Ovf), 64'd0);
        chk("rst_tick_a",  64'(ia.Tick), 64'd0);
        chk("rst_count_b", 64'(ib.Count), 64'd0);

        // Eight events on ch1 with DIV=4
        clr_ticks();
        ia.En = 1'b1; ia.Sel = 2'd1;
        cyc(8);
        ia.En = 1'b0;
        cyc();
        chk("ch1_count", ca(1), 64'd2);
        chk("ch1_ticks", 64'(ta[1]), 64'd2);
        chk("ch0_idle",  ca(0), 64'd0);
        chk("ch2_idle",  ca(2), 64'd0);
        chk("ch3_idle",  ca(3), 64'd0);
        chk("ovf_clean", 64'(ia.Ovf), 64'd0);

        // Clear beats a simultaneous event and drops the partial prescale
        ia.En = 1'b1; ia.Sel = 2'd3;
        cyc(3);
        chk("ch3_pre3", ca(3), 64'd0);
        ia.Clr = 4'b1000;
        cyc();
        ia.Clr = 4'b0000;
        chk("ch3_clr", ca(3), 64'd0);
        chk("ch1_keep", ca(1), 64'd2);
        cyc(3);
        chk("ch3_after3", ca(3), 64'd0);
        cyc();
        chk("ch3_after4", ca(3), 64'd1);
        chk("ch3_tick", 64'(ia.Tick), 64'b1000);

        // Reset during a pending 4th event on ch0
        ia.Sel = 2'd0;
        cyc(3);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        chk("rst_mid_c0", ca(0), 64'd0);
        chk("rst_mid_t0", 64'(ia.Tick[0]), 64'd0);
        chk("rst_mid_c1", ca(1), 64'd0);
        cyc(3);
        chk("c0_restart3", ca(0), 64'd0);
        cyc();
        chk("c0_restart4", ca(0), 64'd1);

        // Multi-bit clear
        ia.Sel = 2'd2;
        cyc(4);
        ia.En = 1'b0;
        cyc();
        chk("c2_pre_clr", ca(2), 64'd1);
        ia.Clr = 4'b0101;
        cyc();
        ia.Clr = 4'b0000;
        chk("multi_clr0", ca(0), 64'd0);
        chk("multi_clr2", ca(2), 64'd0);

        // Narrow bank: out-of-range select is discarded
        clr_ticks();
        ib.En = 1'b1; ib.Sel = 2'd3;
        cyc(10);
        chk("sel3_count", 64'(ib.Count), 64'd0);
        chk("sel3_ticks", 64'(tb[0] + tb[1] + tb[2]), 64'd0);

        // ch0 to the top and one past
        ib.Sel = 2'd0;
        cyc(15);
        chk("b0_at15", cb(0), 64'd15);
        chk("b0_ovf15", 64'(ib.Ovf[0]), 64'd0);
        cyc();
        ib.En = 1'b0;
        cyc();
`ifdef ECB_SATURATE_EN
        chk("b0_at16", cb(0), 64'd15);
        chk("b0_ticks", 64'(tb[0]), 64'd15);
`else
        chk("b0_at16", cb(0), 64'd0);
        chk("b0_ticks", 64'(tb[0]), 64'd16);
`endif
        chk("b0_ovf16", 64'(ib.Ovf[0]), 64'd1);

        // ch2: twenty events
        ib.En = 1'b1; ib.Sel = 2'd2;
        cyc(15);
        chk("b2_at15", cb(2), 64'd15);
        cyc();
        chk("b2_ovf16", 64'(ib.Ovf[2]), 64'd1);
        cyc(4);
        ib.En = 1'b0;
        cyc();
`ifdef ECB_SATURATE_EN
        chk("b2_at20", cb(2), 64'd15);
        chk("b2_ticks", 64'(tb[2]), 64'd15);
`else
        chk("b2_at20", cb(2), 64'd4);
        chk("b2_ticks", 64'(tb[2]), 64'd20);
`endif
        chk("b2_ovf20", 64'(ib.Ovf[2]), 64'd1);
        chk("b0_ovf_sticky", 64'(ib.Ovf[0]), 64'd1);

        // Clear drops sticky overflow on ch0 only
        ib.Clr = 3'b001;
        cyc();
        ib.Clr = 3'b000;
        chk("b0_ovf_clr", 64'(ib.Ovf), 64'b100);
        chk("b0_cnt_clr", cb(0), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
